alu_issue_ctrl: RTL and testbench

//  Upstream issue/writeback stage for the 8-bit ALU. Holds a small register file and accepts one

---
 rtl/alu_issue_if.sv | 43 ++++
 rtl/alu_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Issue/writeback bundle between the instruction source, the combinational
// ALU and alu_issue_ctrl. The controller uses the slave modport. The master
// side is the source and ALU environment: it offers instructions and loads,
// and it returns the ALU result.
interface alu_issue_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr_op;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] instr_rs1;
  logic [ADDR_W-1:0] instr_rs2;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic              wb_carry;
  logic              div_zero;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    input  load_en, load_addr, load_data, alu_out, alu_carry, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_sel, wb_valid, wb_data, wb_carry,
    output div_zero, dbg_data
  );

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    output load_en, load_addr, load_data, alu_out, alu_carry, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_sel, wb_valid, wb_data, wb_carry,
    input  div_zero, dbg_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for the 8-bit combinational ALU.
// This block owns a small register file and accepts one instruction every
// three cycles. It registers the operands and select code into the ALU, then
// writes the ALU result back to the destination register.
// Optional feature: define ALU_DIVZERO_GUARD_EN to replace a divide by zero
// with an all-ones result and to raise div_zero.
//
// state  | meaning
// S_IDLE | ready for an instruction; direct loads are honoured here
// S_EXEC | operands are stable at the ALU; the result commits at the edge
// S_WB   | wb_valid pulse for one cycle
module alu_issue_ctrl #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 2,
  parameter logic [DATA_W-1:0] REG_INIT = '0
) (
  input  logic      clk,
  input  logic      reset,
  alu_issue_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, wb_data_q;
  logic [3:0]        alu_sel_q;
  logic              wb_carry_q;
  logic              accept, commit, guard_hit;
  logic [DATA_W-1:0] wr_data;
  logic              wr_carry;

  // Next-state logic and the one-cycle accept/commit strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.instr_valid) begin
        accept  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        commit  = 1'b1;
        state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset drops any in-flight instruction
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

`ifdef ALU_DIVZERO_GUARD_EN
  localparam logic [3:0] OP_DIV = 4'b0011;
  logic div_zero_q;

  assign guard_hit = (alu_sel_q == OP_DIV) && (alu_b_q == '0);

  // The divide-by-zero flag follows each writeback
  always_ff @(posedge clk) begin
    if (reset)       div_zero_q <= 1'b0;
    else if (commit) div_zero_q <= guard_hit;
  end

  assign bus.div_zero = div_zero_q;
`else
  assign guard_hit    = 1'b0;
  assign bus.div_zero = 1'b0;
`endif

  assign wr_data  = guard_hit ? '1 : bus.alu_out;
  assign wr_carry = guard_hit ? 1'b0 : bus.alu_carry;

  // Operand capture on accept; reads use register values from before a coincident load
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= 4'b0000;
      rd_q      <= '0;
    end else if (accept) begin
      alu_a_q   <= regs[bus.instr_rs1];
      alu_b_q   <= regs[bus.instr_rs2];
      alu_sel_q <= bus.instr_op;
      rd_q      <= bus.instr_rd;
    end
  end

  // Register file: writeback in EXEC, direct load only in IDLE (the two never coincide)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_INIT;
    end else if (commit) begin
      regs[rd_q] <= wr_data;
    end else if (state_q == S_IDLE && bus.load_en) begin
      regs[bus.load_addr] <= bus.load_data;
    end
  end

  // Writeback data and carry, held until the next writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data_q  <= '0;
      wb_carry_q <= 1'b0;
    end else if (commit) begin
      wb_data_q  <= wr_data;
      wb_carry_q <= wr_carry;
    end
  end

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.wb_valid    = (state_q == S_WB);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_sel     = alu_sel_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_carry    = wb_carry_q;
  assign bus.dbg_data    = regs[bus.dbg_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl. The bench supplies a stand-in combinational ALU.
// A timestamp-based transaction model predicts every output on every cycle.
// Directed scenarios add hand-computed literal expectations.
// Define ALU_DIVZERO_GUARD_EN for both the bench and the RTL to cover the guard build.
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  alu_issue_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  alu_issue_ctrl #(.DATA_W(8), .ADDR_W(2), .REG_INIT(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: {carry, result}. Codes 8..15 produce an arbitrary but defined pattern.
  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return (b == 8'h00) ? 9'h1EE : {1'b0, a / b};
      4'd4:    return {a, 1'b0};
      4'd5:    return {a[0], 1'b0, a[7:1]};
      4'd6:    return {1'b0, a | b};
      4'd7:    return {1'b0, a ^ b};
      default: return {op[0], a ^ ~b ^ {op, op}};
    endcase
  endfunction

  assign {bus.alu_carry, bus.alu_out} = alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // cyc counts clock edges. An accept at edge E sets acc_cyc=E. The result commits
  // at E+1, wb_valid is expected in the cycle after E+1, and ready returns after E+2.
  int         cyc = 0;
  int         acc_cyc = -100;
  int         wb_cyc = -100;
  bit         live = 0;
  bit         inflight = 0;
  logic [7:0] m_rf [4];
  logic [7:0] m_a, m_b, m_wd;
  logic [3:0] m_sel;
  logic [1:0] m_rd;
  logic       m_wc, m_dz;

  always @(posedge clk) begin
    if (reset) begin
      live = 1;
      inflight = 0;
      acc_cyc = -100;
      wb_cyc = -100;
      for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
      m_a = 8'h00; m_b = 8'h00; m_sel = 4'h0; m_rd = 2'd0;
      m_wd = 8'h00; m_wc = 1'b0; m_dz = 1'b0;
    end else if (live) begin
      bit         rdy;
      logic [8:0] res;
      rdy = (cyc >= acc_cyc + 2);
      if (inflight && cyc == acc_cyc) begin
        res = alu_fn(m_sel, m_a, m_b);
        m_dz = 1'b0;
`ifdef ALU_DIVZERO_GUARD_EN
        if (m_sel == 4'd3 && m_b == 8'h00) begin
          res = {1'b0, 8'hFF};
          m_dz = 1'b1;
        end
`endif
        m_rf[m_rd] = res[7:0];
        m_wd = res[7:0];
        m_wc = res[8];
        wb_cyc = cyc + 1;
        inflight = 0;
      end
      if (rdy && bus.instr_valid) begin
        m_a = m_rf[bus.instr_rs1];
        m_b = m_rf[bus.instr_rs2];
        m_sel = bus.instr_op;
        m_rd = bus.instr_rd;
        acc_cyc = cyc + 1;
        inflight = 1;
      end
      if (rdy && bus.load_en) m_rf[bus.load_addr] = bus.load_data;
    end
    cyc++;
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (live) begin
      chk("instr_ready", 32'(bus.instr_ready), 32'(cyc >= acc_cyc + 2));
      chk("wb_valid", 32'(bus.wb_valid), 32'(cyc == wb_cyc));
      chk("alu_a", 32'(bus.alu_a), 32'(m_a));
      chk("alu_b", 32'(bus.alu_b), 32'(m_b));
      chk("alu_sel", 32'(bus.alu_sel), 32'(m_sel));
      chk("wb_data", 32'(bus.wb_data), 32'(m_wd));
      chk("wb_carry", 32'(bus.wb_carry), 32'(m_wc));
      chk("div_zero", 32'(bus.div_zero), 32'(m_dz));
      chk("dbg_data", 32'(bus.dbg_data), 32'(m_rf[bus.dbg_addr]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    bus.load_en = 1'b1; bus.load_addr = a; bus.load_data = d;
    tick();
    bus.load_en = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 8 && !bus.instr_ready; i++) tick();
    chk("ready_timeout", 32'(bus.instr_ready), 32'd1);
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
    bus.instr_op = op; bus.instr_rd = rd; bus.instr_rs1 = rs1; bus.instr_rs2 = rs2;
  endtask

  // Issue one instruction and check its writeback against hand-computed values
  task automatic run_op(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [7:0] exp_d, input logic exp_c);
    wait_ready();
    set_instr(op, rd, rs1, rs2);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    chk("lit_ready_low", 32'(bus.instr_ready), 32'd0);
    chk("lit_no_wb_yet", 32'(bus.wb_valid), 32'd0);
    tick();
    chk("lit_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("lit_wb_data", 32'(bus.wb_data), 32'(exp_d));
    chk("lit_wb_carry", 32'(bus.wb_carry), 32'(exp_c));
    bus.dbg_addr = rd;
    #1;
    chk("lit_rd_value", 32'(bus.dbg_data), 32'(exp_d));
    tick();
    chk("lit_wb_pulse_end", 32'(bus.wb_valid), 32'd0);
  endtask

  initial begin
    bus.instr_valid = 1'b0; bus.instr_op = 4'h0; bus.instr_rd = 2'd0;
    bus.instr_rs1 = 2'd0; bus.instr_rs2 = 2'd0; bus.load_en = 1'b0;
    bus.load_addr = 2'd0; bus.load_data = 8'h00; bus.dbg_addr = 2'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("lit_reset_ready", 32'(bus.instr_ready), 32'd1);
    chk("lit_reset_wb_data", 32'(bus.wb_data), 32'd0);

    // 1: simple add
    load(2'd1, 8'h0F);
    load(2'd2, 8'h07);
    run_op(4'b0000, 2'd3, 2'd1, 2'd2, 8'h16, 1'b0);

    // 2: carry out of add and subtract
    load(2'd0, 8'hFF);
    load(2'd1, 8'h01);
    run_op(4'b0000, 2'd2, 2'd0, 2'd1, 8'h00, 1'b1);
    run_op(4'b0001, 2'd3, 2'd1, 2'd0, 8'h02, 1'b1);

    // 3: back-to-back with valid held high; the second instruction reads the updated R1
    load(2'd1, 8'h81);
    set_instr(4'b0100, 2'd1, 2'd1, 2'd1);
    bus.instr_valid = 1'b1;
    tick();
    set_instr(4'b0000, 2'd2, 2'd1, 2'd1);
    chk("lit_b2b_ready0", 32'(bus.instr_ready), 32'd0);
    tick();
    chk("lit_b2b_ready1", 32'(bus.instr_ready), 32'd0);
    chk("lit_b2b_wb1", 32'(bus.wb_valid), 32'd1);
    chk("lit_b2b_data1", 32'(bus.wb_data), 32'h02);
    chk("lit_b2b_carry1", 32'(bus.wb_carry), 32'd1);
    tick();
    chk("lit_b2b_ready2", 32'(bus.instr_ready), 32'd1);
    tick();
    bus.instr_valid = 1'b0;
    chk("lit_b2b_alu_a", 32'(bus.alu_a), 32'h02);
    tick();
    chk("lit_b2b_wb2", 32'(bus.wb_valid), 32'd1);
    chk("lit_b2b_data2", 32'(bus.wb_data), 32'h04);
    chk("lit_b2b_carry2", 32'(bus.wb_carry), 32'd0);
    tick();

    // 4: divide by zero, then an add clears the flag
    load(2'd1, 8'h20);
    load(2'd2, 8'h00);
`ifdef ALU_DIVZERO_GUARD_EN
    run_op(4'b0011, 2'd3, 2'd1, 2'd2, 8'hFF, 1'b0);
    chk("lit_div_zero_set", 32'(bus.div_zero), 32'd1);
`else
    run_op(4'b0011, 2'd3, 2'd1, 2'd2, 8'hEE, 1'b1);
    chk("lit_div_zero_off", 32'(bus.div_zero), 32'd0);
`endif
    run_op(4'b0000, 2'd0, 2'd1, 2'd2, 8'h20, 1'b0);
    chk("lit_div_zero_clr", 32'(bus.div_zero), 32'd0);

    // Undefined opcodes pass through, including rs1 == rs2
    run_op(4'hA, 2'd0, 2'd1, 2'd2, 8'h75, 1'b0);
    run_op(4'hF, 2'd1, 2'd0, 2'd0, 8'h00, 1'b1);

    // 5: reset while in EXEC drops the instruction
    wait_ready();
    set_instr(4'b0000, 2'd3, 2'd0, 2'd0);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("lit_rst_no_wb", 32'(bus.wb_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = 2'(i);
      #1;
      chk("lit_rst_regfile", 32'(bus.dbg_data), 32'h00);
    end
    reset = 1'b0;
    tick();
    chk("lit_rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("lit_rst_wb_valid", 32'(bus.wb_valid), 32'd0);

    // 6: a load that coincides with an accept; later loads in EXEC/WB are ignored
    load(2'd1, 8'h10);
    set_instr(4'b0000, 2'd3, 2'd1, 2'd0);
    bus.instr_valid = 1'b1;
    bus.load_en = 1'b1; bus.load_addr = 2'd1; bus.load_data = 8'h33;
    tick();
    bus.instr_valid = 1'b0;
    chk("lit_coinc_alu_a", 32'(bus.alu_a), 32'h10);
    bus.dbg_addr = 2'd1;
    #1;
    chk("lit_coinc_r1", 32'(bus.dbg_data), 32'h33);
    bus.load_data = 8'h55;
    tick();
    chk("lit_coinc_wb", 32'(bus.wb_data), 32'h10);
    tick();
    bus.load_en = 1'b0;
    chk("lit_busy_load_ignored", 32'(bus.dbg_data), 32'h33);
    tick();
    chk("lit_r1_final", 32'(bus.dbg_data), 32'h33);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
